// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared types and constants for the pipeline hazard controller:
//               FSM state encoding, operand forward-select codes and the
//               register-address width.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

  localparam int REG_AW = 4;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_reg_match.sv
`default_nettype none
// ============================================================================
// Module      : reg_match
// Description : Register-number equality gated by a valid bit. Every
//               source/destination comparison in pipe_ctrl goes through this.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_match
  import pipe_ctrl_pkg::*;
(
  input  logic              valid,
  input  logic [REG_AW-1:0] a,
  input  logic [REG_AW-1:0] b,
  output logic              match
);

  // Register 0 is an ordinary register, so no special-casing of address zero.
  assign match = valid & (a == b);

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Five-stage pipeline hazard controller. Freezes the pipe while
//               a data-memory access is pending (with timeout and sticky
//               error), stalls on load-use, flushes on taken branch, selects
//               operand forwarding and counts decode-stall cycles.
//               Optional feature macro: PIPE_CTRL_FWD_EN (operand forwarding;
//               when undefined, any in-flight producer in E/M stalls decode).
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] RA1D,
  input  logic [REG_AW-1:0] RA2D,
  input  logic              UseRA1D,
  input  logic              UseRA2D,
  input  logic [REG_AW-1:0] RA1E,
  input  logic [REG_AW-1:0] RA2E,
  input  logic [REG_AW-1:0] WA3E,
  input  logic              RegWriteE,
  input  logic              MemtoRegE,
  input  logic [REG_AW-1:0] WA3M,
  input  logic              RegWriteM,
  input  logic [REG_AW-1:0] WA3W,
  input  logic              RegWriteW,
  input  logic              MemReqM,
  input  logic              MemAck,
  input  logic              BranchTakenE,
  output logic              writeF,
  output logic              writeD,
  output logic              writeE,
  output logic              writeM,
  output logic              writeW,
  output logic              flushD,
  output logic              flushE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              MemErr,
  output logic [CNT_W-1:0]  StallCount
);

  localparam int                WC_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WC_W-1:0]   WC_LAST = WC_W'(MEM_TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [WC_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic               mem_err_q, mem_err_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic               freeze;
  logic               timeout;
  logic               stall;
  logic [1:0]         fwd_a;
  logic [1:0]         fwd_b;

  // Decode sources against the execute-stage destination (shared by both builds).
  logic d1_e, d2_e;
  reg_match u_d1_e (.valid(UseRA1D & RegWriteE), .a(RA1D), .b(WA3E), .match(d1_e));
  reg_match u_d2_e (.valid(UseRA2D & RegWriteE), .a(RA2D), .b(WA3E), .match(d2_e));

`ifdef PIPE_CTRL_FWD_EN
  logic a_m, a_w, b_m, b_w;
  reg_match u_a_m (.valid(RegWriteM), .a(RA1E), .b(WA3M), .match(a_m));
  reg_match u_a_w (.valid(RegWriteW), .a(RA1E), .b(WA3W), .match(a_w));
  reg_match u_b_m (.valid(RegWriteM), .a(RA2E), .b(WA3M), .match(b_m));
  reg_match u_b_w (.valid(RegWriteW), .a(RA2E), .b(WA3W), .match(b_w));

  // Only a load result cannot be forwarded in time; the M stage wins over W.
  always_comb begin
    stall = MemtoRegE & (d1_e | d2_e);
    fwd_a = a_m ? FWD_M : (a_w ? FWD_W : FWD_RF);
    fwd_b = b_m ? FWD_M : (b_w ? FWD_W : FWD_RF);
  end
`else
  logic d1_m, d2_m;
  logic unused_fwd;
  reg_match u_d1_m (.valid(UseRA1D & RegWriteM), .a(RA1D), .b(WA3M), .match(d1_m));
  reg_match u_d2_m (.valid(UseRA2D & RegWriteM), .a(RA2D), .b(WA3M), .match(d2_m));
  assign unused_fwd = ^{RA1E, RA2E, WA3W, RegWriteW};

  // Without forwarding, any producer still in E or M must retire before decode reads.
  always_comb begin
    stall = (MemtoRegE & (d1_e | d2_e)) | d1_e | d2_e | d1_m | d2_m;
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
  end
`endif

  // Memory-wait FSM: next state, wait counter, freeze and timeout detection.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    freeze     = 1'b0;
    timeout    = 1'b0;
    case (state_q)
      RUN: begin
        if (MemReqM && !MemAck) begin
          freeze     = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      MEM_WAIT: begin
        wait_cnt_d = wait_cnt_q + WC_W'(1);
        if (MemAck) begin
          state_d = RUN;
        end else if (wait_cnt_q == WC_LAST) begin
          timeout = 1'b1;
          state_d = RUN;
        end else begin
          freeze = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Pipe-register enables, flushes and forward selects by priority; reset forces all low.
  always_comb begin
    writeF    = 1'b1;
    writeD    = 1'b1;
    writeE    = 1'b1;
    writeM    = 1'b1;
    writeW    = 1'b1;
    flushD    = 1'b0;
    flushE    = 1'b0;
    ForwardAE = fwd_a;
    ForwardBE = fwd_b;
    if (!reset || freeze) begin
      writeF = 1'b0;
      writeD = 1'b0;
      writeE = 1'b0;
      writeM = 1'b0;
      writeW = 1'b0;
    end else if (BranchTakenE) begin
      flushD = 1'b1;
      flushE = 1'b1;
    end else if (stall) begin
      writeF = 1'b0;
      writeD = 1'b0;
      flushE = 1'b1;
    end
    if (!reset) begin
      ForwardAE = FWD_RF;
      ForwardBE = FWD_RF;
    end
  end

  // Sticky error and saturating decode-stall counter.
  always_comb begin
    mem_err_d   = mem_err_q | timeout;
    stall_cnt_d = stall_cnt_q;
    if (!writeD && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign MemErr     = mem_err_q;
  assign StallCount = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Self-checking bench for pipe_ctrl: table of combinational
//               hazard vectors plus directed multi-cycle sequences for memory
//               freeze, timeout, reset-in-wait and counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // Packed outputs: {writeF,D,E,M,W, flushD,flushE, ForwardAE, ForwardBE}
  localparam logic [10:0] NORM  = 11'b11111_00_00_00;
  localparam logic [10:0] STALL = 11'b00111_01_00_00;
  localparam logic [10:0] BRNCH = 11'b11111_11_00_00;
  localparam logic [10:0] ZERO  = 11'b00000_00_00_00;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] RA1D = '0, RA2D = '0, RA1E = '0, RA2E = '0, WA3E = '0, WA3M = '0, WA3W = '0;
  logic       UseRA1D = 0, UseRA2D = 0, RegWriteE = 0, MemtoRegE = 0, RegWriteM = 0;
  logic       RegWriteW = 0, MemReqM = 0, MemAck = 0, BranchTakenE = 0;
  logic       writeF, writeD, writeE, writeM, writeW, flushD, flushE, MemErr;
  logic [1:0] ForwardAE, ForwardBE;
  logic [3:0] StallCount;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .UseRA1D(UseRA1D), .UseRA2D(UseRA2D),
    .RA1E(RA1E), .RA2E(RA2E), .WA3E(WA3E), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
    .WA3M(WA3M), .RegWriteM(RegWriteM), .WA3W(WA3W), .RegWriteW(RegWriteW),
    .MemReqM(MemReqM), .MemAck(MemAck), .BranchTakenE(BranchTakenE),
    .writeF(writeF), .writeD(writeD), .writeE(writeE), .writeM(writeM), .writeW(writeW),
    .flushD(flushD), .flushE(flushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MemErr(MemErr), .StallCount(StallCount)
  );

  typedef struct {
    logic [3:0] ra1d, ra2d;
    logic       u1, u2;
    logic [3:0] ra1e, ra2e, wa3e;
    logic       rwe, m2r;
    logic [3:0] wa3m;
    logic       rwm;
    logic [3:0] wa3w;
    logic       rww, br;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(logic [3:0] ra1d, logic [3:0] ra2d, logic u1, logic u2,
                              logic [3:0] ra1e, logic [3:0] ra2e, logic [3:0] wa3e,
                              logic rwe, logic m2r, logic [3:0] wa3m, logic rwm,
                              logic [3:0] wa3w, logic rww, logic br, logic [10:0] exp);
    vec_t v;
    v.ra1d = ra1d; v.ra2d = ra2d; v.u1 = u1; v.u2 = u2;
    v.ra1e = ra1e; v.ra2e = ra2e; v.wa3e = wa3e; v.rwe = rwe; v.m2r = m2r;
    v.wa3m = wa3m; v.rwm = rwm; v.wa3w = wa3w; v.rww = rww; v.br = br; v.exp = exp;
    return v;
  endfunction

  function automatic logic [10:0] outs();
    return {writeF, writeD, writeE, writeM, writeW, flushD, flushE, ForwardAE, ForwardBE};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    RA1D = '0; RA2D = '0; RA1E = '0; RA2E = '0; WA3E = '0; WA3M = '0; WA3W = '0;
    UseRA1D = 0; UseRA2D = 0; RegWriteE = 0; MemtoRegE = 0; RegWriteM = 0;
    RegWriteW = 0; MemReqM = 0; MemAck = 0; BranchTakenE = 0;
  endtask

  task automatic load_use();
    idle();
    RA1D = 4'd5; UseRA1D = 1; WA3E = 4'd5; RegWriteE = 1; MemtoRegE = 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    reset = 0;
    @(negedge clk);
    #1;
    chk("reset_outs", 32'(outs()), 32'(ZERO));
    chk("reset_cnt", 32'(StallCount), 32'd0);
    chk("reset_err", 32'(MemErr), 32'd0);
    reset = 1;
  endtask

  initial begin
    // Hazard vector table (state is RUN, no memory request).
    vecs[0]  = mk(1, 0, 1, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, NORM);
    vecs[1]  = mk(5, 0, 1, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, STALL);
    vecs[2]  = mk(0, 9, 0, 1, 0, 0, 9, 1, 1, 0, 0, 0, 0, 0, STALL);
    vecs[3]  = mk(5, 0, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, NORM);
    vecs[4]  = mk(5, 0, 1, 0, 0, 0, 5, 0, 1, 0, 0, 0, 0, 0, NORM);
    vecs[5]  = mk(5, 0, 1, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 1, BRNCH);
    vecs[6]  = mk(0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, STALL);
    vecs[7]  = mk(3, 0, 1, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, FWD ? NORM : STALL);
    vecs[8]  = mk(0, 7, 0, 1, 7, 0, 0, 0, 0, 7, 1, 0, 0, 0, FWD ? (NORM | 11'b1000) : STALL);
    vecs[9]  = mk(0, 0, 0, 0, 7, 7, 0, 0, 0, 7, 1, 7, 1, 0, FWD ? (NORM | 11'b1010) : NORM);
    vecs[10] = mk(0, 0, 0, 0, 7, 0, 0, 0, 0, 7, 0, 7, 1, 0, FWD ? (NORM | 11'b0100) : NORM);
    vecs[11] = mk(0, 0, 0, 0, 7, 8, 0, 0, 0, 8, 1, 7, 1, 0, FWD ? (NORM | 11'b0110) : NORM);

    do_reset();

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      RA1D = vecs[i].ra1d; RA2D = vecs[i].ra2d; UseRA1D = vecs[i].u1; UseRA2D = vecs[i].u2;
      RA1E = vecs[i].ra1e; RA2E = vecs[i].ra2e; WA3E = vecs[i].wa3e;
      RegWriteE = vecs[i].rwe; MemtoRegE = vecs[i].m2r;
      WA3M = vecs[i].wa3m; RegWriteM = vecs[i].rwm; WA3W = vecs[i].wa3w; RegWriteW = vecs[i].rww;
      BranchTakenE = vecs[i].br; MemReqM = 0; MemAck = 0;
      #1;
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end

    // Single load-use stall cycle, then branch overriding load-use.
    do_reset();
    @(negedge clk); load_use(); #1;
    chk("lu_outs", 32'(outs()), 32'(STALL));
    @(negedge clk); idle(); #1;
    chk("lu_cnt", 32'(StallCount), 32'd1);
    chk("lu_release", 32'(outs()), 32'(NORM));
    @(negedge clk); load_use(); BranchTakenE = 1; #1;
    chk("br_lu_outs", 32'(outs()), 32'(BRNCH));
    @(negedge clk); idle(); #1;
    chk("br_lu_cnt", 32'(StallCount), 32'd1);

    // Memory wait of three cycles, acknowledged on the fourth.
    do_reset();
    @(negedge clk); MemReqM = 1; BranchTakenE = 1; #1;
    chk("mw_freeze0", 32'(outs()), 32'(ZERO));
    @(negedge clk); BranchTakenE = 0; #1;
    chk("mw_freeze1", 32'(outs()), 32'(ZERO));
    @(negedge clk); #1;
    chk("mw_freeze2", 32'(outs()), 32'(ZERO));
    @(negedge clk); MemAck = 1; #1;
    chk("mw_ack", 32'(outs()), 32'(NORM));
    @(negedge clk); MemReqM = 0; MemAck = 0; #1;
    chk("mw_back_run", 32'(outs()), 32'(NORM));
    chk("mw_cnt", 32'(StallCount), 32'd3);
    chk("mw_no_err", 32'(MemErr), 32'd0);

    // Timeout with MEM_TIMEOUT=4: one RUN freeze cycle plus three MEM_WAIT cycles frozen.
    do_reset();
    @(negedge clk); MemReqM = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("to_freeze%0d", i), 32'(outs()), 32'(ZERO));
      chk($sformatf("to_err_low%0d", i), 32'(MemErr), 32'd0);
      @(negedge clk);
    end
    #1;
    chk("to_release", 32'(outs()), 32'(NORM));
    chk("to_err_before", 32'(MemErr), 32'd0);
    @(negedge clk); #1;
    chk("to_err_set", 32'(MemErr), 32'd1);
    chk("to_refreeze", 32'(outs()), 32'(ZERO));
    // Now in MEM_WAIT again: assert reset mid-wait.
    @(negedge clk); reset = 0; #1;
    chk("rst_mw_outs", 32'(outs()), 32'(ZERO));
    chk("rst_mw_cnt_before", 32'(StallCount), 32'd5);
    chk("rst_mw_err_before", 32'(MemErr), 32'd1);
    @(negedge clk); #1;
    chk("rst_mw_err", 32'(MemErr), 32'd0);
    chk("rst_mw_cnt", 32'(StallCount), 32'd0);
    reset = 1; MemReqM = 0; #1;
    chk("rst_mw_run", 32'(outs()), 32'(NORM));

    // Sticky error: timeout again, then confirm MemErr holds with no activity.
    @(negedge clk); MemReqM = 1;
    repeat (5) @(negedge clk);
    MemReqM = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("err_sticky", 32'(MemErr), 32'd1);

    // Saturation of the 4-bit stall counter.
    do_reset();
    @(negedge clk); load_use();
    repeat (20) @(negedge clk);
    idle(); #1;
    chk("cnt_sat", 32'(StallCount), 32'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
